// File: rtl/raymarch_pkg.sv
// Shared types and constants for the raymarch frame writer; the FRAME_WRITER_RGB565_EN
// macro selects a 16-bit RGB565 framebuffer word instead of the default 24-bit RGB888 word.
package raymarch_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int CORD_W    = 10;
  localparam int FB_ADDR_W = 19;

`ifdef FRAME_WRITER_RGB565_EN
  localparam int FB_W = 16;
`else
  localparam int FB_W = 24;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fw_state_t;

  function automatic logic [FB_W-1:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b);
`ifdef FRAME_WRITER_RGB565_EN
    return {r[7:3], g[7:2], b[7:3]};
`else
    return {r, g, b};
`endif
  endfunction

endpackage

// File: rtl/fw_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two >= 2.
// The head is visible the cycle after a push into an empty FIFO; a push while full is dropped.
module fw_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wr_dat,
  input  logic                     pop,
  output logic [W-1:0]             rd_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat;
  end

  // Head is forced to zero when empty so the write port reads clean after reset.
  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign count  = count_q;
  assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/raymarch_frame_writer.sv
// Raster-scans pixel coordinates into a fixed-latency raymarcher and streams its colours to the framebuffer.
// Credit-limited issue keeps the output FIFO from overflowing; FRAME_WRITER_RGB565_EN selects the RGB565 word.
module raymarch_frame_writer
  import raymarch_pkg::*;
#(
  parameter int PIPE_LATENCY = 140,
  parameter int FIFO_DEPTH   = 256,
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CORD_W-1:0]    pixel_x,
  output logic [CORD_W-1:0]    pixel_y,
  input  logic [7:0]           in_red,
  input  logic [7:0]           in_green,
  input  logic [7:0]           in_blue,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [FB_W-1:0]      fb_wdata,
  output logic                 fb_valid,
  input  logic                 fb_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = FB_ADDR_W + FB_W;

  fw_state_t state_q, state_d;

  logic [CORD_W-1:0]    x_q, x_d, y_q, y_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [PIPE_LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [FB_ADDR_W-1:0] dl_addr_q [PIPE_LATENCY];
  logic [FB_ADDR_W-1:0] dl_addr_d [PIPE_LATENCY];

  logic          issue_ok, last_pix, capture;
  logic          fifo_empty, fifo_full, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [QW-1:0] fifo_rd_dat;

  assign last_pix = (x_q == CORD_W'(H_RES - 1)) && (y_q == CORD_W'(V_RES - 1));
  assign capture  = dl_vld_q[PIPE_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue_ok && last_pix) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0 && fifo_empty) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Credits cover both pixels still in the raymarcher and colours already queued.
  always_comb begin
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    issue_ok   = (state_q == RUN) &&
                 (({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (issue_ok) begin
      if (x_q == CORD_W'(H_RES - 1)) begin
        x_d = '0;
        y_d = (y_q == CORD_W'(V_RES - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      addr_d = last_pix ? '0 : addr_q + 1'b1;
    end
    inflight_d = inflight_q + CW'(issue_ok) - CW'(capture);
    dl_vld_d   = {dl_vld_q[PIPE_LATENCY-2:0], issue_ok};
    dl_addr_d[0] = addr_q;
    for (int i = 1; i < PIPE_LATENCY; i++) dl_addr_d[i] = dl_addr_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      inflight_q <= '0;
      dl_vld_q   <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) dl_addr_q[i] <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      dl_vld_q   <= dl_vld_d;
      for (int i = 0; i < PIPE_LATENCY; i++) dl_addr_q[i] <= dl_addr_d[i];
    end
  end

  assign fb_valid = !fifo_empty;
  assign fifo_pop = fb_valid && fb_ready;

  fw_sync_fifo #(
    .W     (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (capture),
    .wr_dat ({dl_addr_q[PIPE_LATENCY-1], pack_rgb(in_red, in_green, in_blue)}),
    .pop    (fifo_pop),
    .rd_dat (fifo_rd_dat),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  assign {fb_addr, fb_wdata} = fifo_rd_dat;
  assign pixel_x = x_q;
  assign pixel_y = y_q;

endmodule

// File: tb/tb_raymarch_frame_writer.sv
// Directed bench for raymarch_frame_writer with a fixed-latency colour stub standing in for the raymarcher.
module tb_raymarch_frame_writer;
  import raymarch_pkg::*;

  localparam int H = 8;
  localparam int V = 4;
  localparam int L = 12;
  localparam int D = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 fb_ready = 1'b1;
  logic                 busy, frame_done, fb_valid;
  logic [9:0]           pixel_x, pixel_y;
  logic [7:0]           in_red, in_green, in_blue;
  logic [18:0]          fb_addr;
  logic [FB_W-1:0]      fb_wdata;

  always #5 clk = ~clk;

  raymarch_frame_writer #(
    .PIPE_LATENCY (L),
    .FIFO_DEPTH   (D),
    .H_RES        (H),
    .V_RES        (V)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .in_red     (in_red),
    .in_green   (in_green),
    .in_blue    (in_blue),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .fb_valid   (fb_valid),
    .fb_ready   (fb_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] f_r(input logic [9:0] x, input logic [9:0] y);
    return 8'hFF ^ (x[7:0] * 8'd29 + y[7:0]);
  endfunction
  function automatic logic [7:0] f_g(input logic [9:0] x, input logic [9:0] y);
    return 8'h80 ^ ((y[7:0] * 8'd53) ^ x[7:0]);
  endfunction
  function automatic logic [7:0] f_b(input logic [9:0] x, input logic [9:0] y);
    return 8'h08 + x[7:0] + y[7:0] * 8'd8;
  endfunction

  function automatic logic [FB_W-1:0] exp_word(input int a);
    logic [9:0] x, y;
    logic [7:0] r, g, b;
    x = 10'(a % H);
    y = 10'(a / H);
    r = f_r(x, y);
    g = f_g(x, y);
    b = f_b(x, y);
`ifdef FRAME_WRITER_RGB565_EN
    return {r[7:3], g[7:2], b[7:3]};
`else
    return {r, g, b};
`endif
  endfunction

`ifdef FRAME_WRITER_RGB565_EN
  localparam logic [31:0] FIRST_WORD = 32'h0000_FC01;
`else
  localparam logic [31:0] FIRST_WORD = 32'h00FF_8008;
`endif

  // Stub: colour for the coordinate presented L cycles earlier.
  logic [19:0] hist [0:L];
  initial for (int i = 0; i <= L; i++) hist[i] = '0;
  always @(negedge clk) begin
    for (int i = L; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {pixel_x, pixel_y};
  end
  assign in_red   = f_r(hist[L][19:10], hist[L][9:0]);
  assign in_green = f_g(hist[L][19:10], hist[L][9:0]);
  assign in_blue  = f_b(hist[L][19:10], hist[L][9:0]);

  bit bp_mode = 1'b0;
  int bp_cnt  = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode) begin
      bp_cnt   = (bp_cnt + 1) % 4;
      fb_ready = (bp_cnt == 3);
    end else begin
      fb_ready = 1'b1;
    end
  end

  int exp_idx  = 0;
  int n_writes = 0;
  int n_done   = 0;
  logic prev_stall = 1'b0;
  logic [18:0] prev_addr = '0;
  logic [FB_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", fb_valid, 1'b1);
        check_eq("stall_addr", fb_addr, prev_addr);
        check_eq("stall_data", fb_wdata, prev_data);
      end
      if (bp_mode) check_eq("fifo_bound", (dut.fifo_count <= D), 1'b1);
      if (fb_valid && fb_ready) begin
        if (exp_idx == 0) check_eq("rgb_const", fb_wdata, FIRST_WORD);
        check_eq("wr_addr", fb_addr, exp_idx);
        check_eq("wr_data", fb_wdata, exp_word(exp_idx));
        exp_idx++;
        n_writes++;
      end
      if (frame_done) n_done++;
      prev_stall = fb_valid && !fb_ready;
      prev_addr  = fb_addr;
      prev_data  = fb_wdata;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!frame_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", frame_done, 1'b1);
    @(negedge clk);
  endtask

  task automatic frame_end_checks(input string tag, input int w0, input int d0);
    repeat (L + 4) @(negedge clk);
    check_eq({tag, "_writes"}, n_writes - w0, H * V);
    check_eq({tag, "_done_cnt"}, n_done - d0, 1);
    check_eq({tag, "_busy_low"}, busy, 1'b0);
    check_eq({tag, "_fb_idle"}, fb_valid, 1'b0);
  endtask

  int w0, d0, k;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_px", pixel_x, 0);
    check_eq("rst_py", pixel_y, 0);
    check_eq("rst_valid", fb_valid, 1'b0);
    check_eq("rst_addr", fb_addr, 0);
    check_eq("rst_wdata", fb_wdata, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Full frame with an always-ready sink.
    exp_idx = 0; w0 = n_writes; d0 = n_done;
    pulse_start();
    @(negedge clk);
    check_eq("busy_after_start", busy, 1'b1);
    wait_done(2000);
    frame_end_checks("full", w0, d0);

    // Line wrap from (H-1,2) to (0,3).
    exp_idx = 0; w0 = n_writes; d0 = n_done;
    pulse_start();
    k = 0;
    while (!(pixel_x == 10'(H - 1) && pixel_y == 10'd2) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_eq("wrap_reached", (k < 500), 1'b1);
    k = 0;
    while (pixel_x == 10'(H - 1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_eq("wrap_x", pixel_x, 0);
    check_eq("wrap_y", pixel_y, 3);
    wait_done(2000);
    frame_end_checks("wrap", w0, d0);

    // Sink stalls three cycles out of four.
    exp_idx = 0; w0 = n_writes; d0 = n_done;
    bp_mode = 1'b1;
    pulse_start();
    wait_done(4000);
    frame_end_checks("bp", w0, d0);
    bp_mode = 1'b0;

    // Reset with five pixels in flight.
    exp_idx = 0;
    pulse_start();
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_valid", fb_valid, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    w0 = n_writes;
    repeat (L + 10) @(negedge clk);
    check_eq("midrst_no_write", n_writes - w0, 0);
    check_eq("midrst_idle", busy, 1'b0);
    exp_idx = 0; w0 = n_writes; d0 = n_done;
    pulse_start();
    wait_done(2000);
    frame_end_checks("postrst", w0, d0);

    // start during RUN is ignored.
    exp_idx = 0; w0 = n_writes; d0 = n_done;
    pulse_start();
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(2000);
    frame_end_checks("restart", w0, d0);
    repeat (20) @(negedge clk);
    check_eq("restart_no_extra", n_writes - w0, H * V);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
